// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level controller for the dinosaur runner game. It holds the
//   IDLE/RUN/OVER state machine and produces the movement tick that paces
//   the dino and obstacle datapath. The tick period shortens as obstacles
//   are passed. It keeps a 4-digit BCD score and a high score, and picks
//   which of the two is sent to the seven-segment decoder.
//
// Ports
//   clk           in   1   system clock
//   restart_n     in   1   asynchronous active-low reset
//   start         in   1   one-cycle pulse from the debounced jump button
//   collide       in   1   collision level, only acted on while running
//   blk_pass      in   1   one-cycle pulse when an obstacle passes the dino
//   show_highest  in   1   1 = display the high score instead of the score
//   game_tick     out  1   one-cycle pulse advancing the datapath
//   spd_period    out  22  current tick period in clk cycles
//   run           out  1   high while running
//   over          out  1   high while the game is over
//   score_bcd     out  16  current score, 4 BCD digits, [15:12] = thousands
//   disp_num      out  16  value routed to the seven-segment decoder
module game_sequencer #(
  parameter logic [21:0] SPD_INIT   = 22'd2_500_000,
  parameter logic [21:0] SPD_MIN    = 22'd500_000,
  parameter logic [21:0] SPD_STEP   = 22'd100_000,
  parameter logic [3:0]  STEP_SCORE = 4'd10
) (
  input  logic        clk,
  input  logic        restart_n,
  input  logic        start,
  input  logic        collide,
  input  logic        blk_pass,
  input  logic        show_highest,
  output logic        game_tick,
  output logic [21:0] spd_period,
  output logic        run,
  output logic        over,
  output logic [15:0] score_bcd,
  output logic [15:0] disp_num
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] tick_cnt_q, tick_cnt_d;
  logic [21:0] spd_q, spd_d;
  logic [3:0]  pass_cnt_q, pass_cnt_d;
  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic        game_tick_q, game_tick_d;
  logic        run_q, over_q;

  // Adds one to a 4-digit BCD value, rippling the carry through the
  // digits. The caller stops the score at 9999 before calling this.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state and datapath logic. A collision ends the cycle's work, so a
  // pass or tick in the same cycle is dropped. The tick compare uses >= so
  // that a period which has just shrunk below the running count still
  // fires on the next cycle and wraps.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = '0;
    spd_d       = spd_q;
    pass_cnt_d  = pass_cnt_q;
    score_d     = score_q;
    high_d      = high_q;
    game_tick_d = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = RUN;
          score_d    = '0;
          pass_cnt_d = '0;
          spd_d      = SPD_INIT;
        end
      end

      RUN: begin
        if (collide) begin
          state_d = OVER;
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end else begin
          if (tick_cnt_q >= spd_q - 22'd1) begin
            game_tick_d = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 22'd1;
          end

          if (blk_pass) begin
            if (score_q != 16'h9999) begin
              score_d = bcdInc(score_q);
            end
            if (pass_cnt_q == STEP_SCORE - 4'd1) begin
              pass_cnt_d = '0;
              // Checked before subtracting so the period cannot wrap.
              if (spd_q >= SPD_MIN + SPD_STEP) begin
                spd_d = spd_q - SPD_STEP;
              end else begin
                spd_d = SPD_MIN;
              end
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. run/over follow the next state so they
  // rise on the first cycle after the transition edge.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      spd_q       <= SPD_INIT;
      pass_cnt_q  <= '0;
      score_q     <= '0;
      high_q      <= '0;
      game_tick_q <= 1'b0;
      run_q       <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      spd_q       <= spd_d;
      pass_cnt_q  <= pass_cnt_d;
      score_q     <= score_d;
      high_q      <= high_d;
      game_tick_q <= game_tick_d;
      run_q       <= (state_d == RUN);
      over_q      <= (state_d == OVER);
    end
  end

  assign game_tick  = game_tick_q;
  assign spd_period = spd_q;
  assign run        = run_q;
  assign over       = over_q;
  assign score_bcd  = score_q;
  assign disp_num   = show_highest ? high_q : score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Self-checking bench for game_sequencer with shortened timing
//   parameters. A behavioural model tracks the game in plain integers
//   (decimal score, passes since start, period as a function of passes)
//   and every clock cycle the DUT outputs are compared against it.
module tb_game_sequencer;

  localparam int INIT  = 20;
  localparam int MINP  = 8;
  localparam int STEP  = 4;
  localparam int STEPS = 3;

  logic        clk = 1'b0;
  logic        restart_n;
  logic        start;
  logic        collide;
  logic        blk_pass;
  logic        show_highest;
  logic        game_tick;
  logic [21:0] spd_period;
  logic        run;
  logic        over;
  logic [15:0] score_bcd;
  logic [15:0] disp_num;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: 0 idle, 1 running, 2 over.
  int mState;
  int mScore;
  int mHigh;
  int mPasses;
  int mPeriod;
  int mSince;
  int eTick;

  game_sequencer #(
    .SPD_INIT  (22'd20),
    .SPD_MIN   (22'd8),
    .SPD_STEP  (22'd4),
    .STEP_SCORE(4'd3)
  ) dut (
    .clk         (clk),
    .restart_n   (restart_n),
    .start       (start),
    .collide     (collide),
    .blk_pass    (blk_pass),
    .show_highest(show_highest),
    .game_tick   (game_tick),
    .spd_period  (spd_period),
    .run         (run),
    .over        (over),
    .score_bcd   (score_bcd),
    .disp_num    (disp_num)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // The period drops by STEP every STEPS passes and never goes below MINP.
  function automatic int periodFor(input int passes);
    int t;
    t = INIT - STEP * (passes / STEPS);
    return (t < MINP) ? MINP : t;
  endfunction

  task automatic modelReset();
    mState  = 0;
    mScore  = 0;
    mHigh   = 0;
    mPasses = 0;
    mPeriod = INIT;
    mSince  = 0;
    eTick   = 0;
  endtask

  task automatic modelStep(input logic s, input logic c, input logic b);
    if (mState == 1) begin
      if (c) begin
        if (mScore > mHigh) mHigh = mScore;
        mState = 2;
        eTick  = 0;
        mSince = 0;
      end else begin
        if (mSince >= mPeriod - 1) begin
          eTick  = 1;
          mSince = 0;
        end else begin
          eTick  = 0;
          mSince = mSince + 1;
        end
        if (b) begin
          if (mScore < 9999) mScore = mScore + 1;
          mPasses = mPasses + 1;
          mPeriod = periodFor(mPasses);
        end
      end
    end else begin
      eTick  = 0;
      mSince = 0;
      if (s) begin
        mState  = 1;
        mScore  = 0;
        mPasses = 0;
        mPeriod = INIT;
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".tick"}, 32'(game_tick), 32'(eTick));
    checkOne({tag, ".run"}, 32'(run), 32'(mState == 1));
    checkOne({tag, ".over"}, 32'(over), 32'(mState == 2));
    checkOne({tag, ".score"}, 32'(score_bcd), 32'(toBcd(mScore)));
    checkOne({tag, ".spd"}, 32'(spd_period), 32'(mPeriod));
    checkOne({tag, ".disp"}, 32'(disp_num),
             32'(show_highest ? toBcd(mHigh) : toBcd(mScore)));
  endtask

  // One clock cycle with the given inputs; outputs are compared 1 unit
  // after the rising edge.
  task automatic applyStimulus(input logic s, input logic c, input logic b);
    start        = s;
    collide      = c;
    blk_pass     = b;
    show_highest = 1'($urandom_range(0, 1));
    @(posedge clk);
    modelStep(s, c, b);
    #1;
    start    = 1'b0;
    collide  = 1'b0;
    blk_pass = 1'b0;
    checkOutput("cyc");
  endtask

  task automatic sendPasses(input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxGap)) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
  endtask

  // Drops the reset between clock edges and checks that outputs clear at
  // once, then releases it on a falling edge.
  task automatic asyncReset(input logic showHigh);
    #2;
    show_highest = showHigh;
    restart_n    = 1'b0;
    modelReset();
    #1;
    checkOutput("rstNow");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstHeld");
    @(negedge clk);
    restart_n = 1'b1;
  endtask

  initial begin
    int gap;
    start        = 1'b0;
    collide      = 1'b0;
    blk_pass     = 1'b0;
    show_highest = 1'b0;
    restart_n    = 1'b1;
    modelReset();

    // Reset state and an idle period with no ticks.
    #2;
    restart_n = 1'b0;
    #1;
    checkOutput("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    restart_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOne("idleScore", 32'(score_bcd), 32'h0);
    checkOne("idleSpd", 32'(spd_period), 32'd20);

    // Start the game and measure the first two tick intervals.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOne("runRise", 32'(run), 32'd1);
    for (int t = 0; t < 2; t++) begin
      gap = 0;
      for (int k = 1; k <= 40; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (game_tick) begin
          gap = k;
          break;
        end
      end
      checkOne("tickGap", 32'(gap), 32'd20);
    end

    // Speed-ups: 3 passes -> 16, 15 passes -> 8, then it stays at 8.
    sendPasses(3, 3);
    checkOne("score3", 32'(score_bcd), 32'h0003);
    checkOne("spd16", 32'(spd_period), 32'd16);
    sendPasses(12, 3);
    checkOne("score15", 32'(score_bcd), 32'h0015);
    checkOne("spd8", 32'(spd_period), 32'd8);
    sendPasses(6, 2);
    checkOne("spdFloor", 32'(spd_period), 32'd8);
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);

    // Collide, then random collide/pass noise while over must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOne("overRise", 32'(over), 32'd1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    asyncReset(1'b1);

    // High score tracking across two games.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    sendPasses(5, 4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOne("collideOver", 32'(over), 32'd1);
    checkOne("collideScore", 32'(score_bcd), 32'h0005);
    show_highest = 1'b1;
    #1;
    checkOne("high5", 32'(disp_num), 32'h0005);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOne("restartScore", 32'(score_bcd), 32'h0000);
    sendPasses(3, 4);
    repeat ($urandom_range(0, 25)) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    show_highest = 1'b1;
    #1;
    checkOne("highKept", 32'(disp_num), 32'h0005);

    // BCD carry and saturation.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendPasses(99, 1);
    checkOne("score99", 32'(score_bcd), 32'h0099);
    sendPasses(1, 0);
    checkOne("score100", 32'(score_bcd), 32'h0100);
    sendPasses(899, 0);
    checkOne("score999", 32'(score_bcd), 32'h0999);
    sendPasses(1, 0);
    checkOne("score1000", 32'(score_bcd), 32'h1000);
    sendPasses(8999, 0);
    checkOne("score9999", 32'(score_bcd), 32'h9999);
    sendPasses(2, 1);
    checkOne("scoreSat", 32'(score_bcd), 32'h9999);

    // Asynchronous reset in the middle of a game clears everything.
    asyncReset(1'b1);
    checkOne("rstHigh", 32'(disp_num), 32'h0000);
    checkOne("rstRun", 32'(run), 32'd0);
    checkOne("rstSpd", 32'(spd_period), 32'd20);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
